// File: rtl/lfsr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_arbiter_pkg
// Description : LFSR tap positions, lock-up value and next-state function
//               shared by the pseudo-random arbiter and its LFSR core.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_arbiter_pkg;

    localparam int unsigned LFSR_W     = 16;
    localparam int unsigned LFSR_TAP_0 = 15;
    localparam int unsigned LFSR_TAP_1 = 12;
    localparam int unsigned LFSR_TAP_2 = 5;
    localparam int unsigned LFSR_TAP_3 = 1;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 16'hFFFF;

    // XNOR feedback: the all-ones state maps onto itself and must never be loaded
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0],
                ~(q[LFSR_TAP_0] ^ q[LFSR_TAP_1] ^ q[LFSR_TAP_2] ^ q[LFSR_TAP_3])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_16bit.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_16bit
// Description : 16-bit XNOR LFSR core; advances when en_i is high and exposes
//               its low bits as a binary way/offset selector.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_16bit
    import lfsr_arbiter_pkg::*;
#(
    parameter logic [LFSR_W-1:0] Seed = 16'h0000,
    parameter int unsigned       WayW = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    output logic [WayW-1:0] refill_way_bin
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= Seed;
        end else if (en_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign refill_way_bin = lfsr_q[WayW-1:0];

endmodule
`default_nettype wire

// File: rtl/lfsr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_arbiter
// Description : NumIn-to-1 valid/ready arbiter whose wrapping priority search
//               starts at an LFSR-derived offset. Optional starvation guard is
//               enabled by defining LFSR_ARBITER_STARVATION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_arbiter
    import lfsr_arbiter_pkg::*;
#(
    parameter int unsigned       NumIn     = 4,
    parameter int unsigned       DataWidth = 32,
    parameter logic [LFSR_W-1:0] Seed      = 16'h0000,
    parameter bit                LockIn    = 1'b1,
    parameter int unsigned       MaxWait   = 15
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumIn-1:0]                   req_i,
    output logic [NumIn-1:0]                   gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]    data_i,
    output logic                               req_o,
    input  logic                               gnt_i,
    output logic [DataWidth-1:0]               data_o,
    output logic [$clog2(NumIn)-1:0]           idx_o
);

    localparam int unsigned IdxW = $clog2(NumIn);

    logic            handshake;
    logic [IdxW-1:0] offset;
    logic [IdxW-1:0] search_idx;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            starve_hit;
    logic [IdxW-1:0] starve_idx;

    assign req_o     = |req_i;
    assign handshake = req_o & gnt_i;

    lfsr_16bit #(
        .Seed (Seed),
        .WayW (IdxW)
    ) u_lfsr (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (handshake),
        .refill_way_bin (offset)
    );

    // NumIn is a power of two, so truncation to IdxW bits is the modulo wrap
    always_comb begin
        search_idx = offset;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            cand = IdxW'(offset + IdxW'(i));
            if (!found && req_i[cand]) begin
                search_idx = cand;
                found      = 1'b1;
            end
        end
    end

`ifdef LFSR_ARBITER_STARVATION_EN
    localparam int unsigned CntW = $clog2(MaxWait + 1);

    logic [NumIn-1:0][CntW-1:0] wait_q;

    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (wait_q[i] == CntW'(MaxWait)) begin
                starve_hit = 1'b1;
                starve_idx = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            for (int i = 0; i < NumIn; i++) begin
                if (!req_i[i]) begin
                    wait_q[i] <= '0;
                end else if (handshake) begin
                    if (idx_o == IdxW'(i)) begin
                        wait_q[i] <= '0;
                    end else if (wait_q[i] != CntW'(MaxWait)) begin
                        wait_q[i] <= wait_q[i] + CntW'(1);
                    end
                end
            end
        end
    end
`else
    assign starve_hit = 1'b0;
    assign starve_idx = '0;
`endif

    generate
        if (LockIn) begin : g_lock
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lock_q     <= 1'b0;
                    lock_idx_q <= '0;
                end else if (handshake) begin
                    lock_q     <= 1'b0;
                end else if (req_o) begin
                    lock_q     <= 1'b1;
                    lock_idx_q <= idx_o;
                end
            end
        end else begin : g_no_lock
            assign lock_q     = 1'b0;
            assign lock_idx_q = '0;
        end
    endgenerate

    // Lock takes precedence over a starvation override
    always_comb begin
        idx_o = search_idx;
        if (lock_q) begin
            idx_o = lock_idx_q;
        end else if (starve_hit) begin
            idx_o = starve_idx;
        end
    end

    always_comb begin
        gnt_o        = '0;
        gnt_o[idx_o] = handshake;
    end

    assign data_o = data_i[idx_o];

    a_num_in_pow2: assert property (@(posedge clk_i)
        (NumIn >= 2) && (NumIn <= 16) && ((NumIn & (NumIn - 1)) == 0));
    a_seed_legal: assert property (@(posedge clk_i) Seed != LFSR_LOCKUP);
    a_max_wait_range: assert property (@(posedge clk_i)
        (MaxWait >= 1) && (MaxWait <= 255));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_req_held_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> req_i[lock_idx_q]);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_arbiter
// Description : Directed self-checking bench for lfsr_arbiter (locked,
//               unlocked and MaxWait=2 instances share one stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_arbiter;

    logic              clk_i;
    logic              rst_ni;
    logic [3:0]        req_i;
    logic              gnt_i;
    logic [3:0][31:0]  data_i;

    logic [3:0]  gnt_a, gnt_b, gnt_c;
    logic        req_a, req_b, req_c;
    logic [31:0] data_a, data_b, data_c;
    logic [1:0]  idx_a, idx_b, idx_c;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_arbiter #(.NumIn(4), .DataWidth(32), .Seed(16'h0000), .LockIn(1'b1), .MaxWait(15)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_a), .data_i(data_i),
        .req_o(req_a), .gnt_i(gnt_i), .data_o(data_a), .idx_o(idx_a));

    lfsr_arbiter #(.NumIn(4), .DataWidth(32), .Seed(16'h0000), .LockIn(1'b0), .MaxWait(15)) dut_nl (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_b), .data_i(data_i),
        .req_o(req_b), .gnt_i(gnt_i), .data_o(data_b), .idx_o(idx_b));

    lfsr_arbiter #(.NumIn(4), .DataWidth(32), .Seed(16'h0000), .LockIn(1'b1), .MaxWait(2)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_c), .data_i(data_i),
        .req_o(req_c), .gnt_i(gnt_i), .data_o(data_c), .idx_o(idx_c));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        req_i  = '0;
        gnt_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    int exp_idx1 [4] = '{0, 1, 3, 2};
    int exp_lfsr1[4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0006};
    int exp_s4   [4];

    initial begin
`ifdef LFSR_ARBITER_STARVATION_EN
        exp_s4 = '{0, 3, 3, 0};
`else
        exp_s4 = '{0, 3, 3, 3};
`endif
        for (int k = 0; k < 4; k++) data_i[k] = 32'hD00D_0000 + 32'(k);
        req_i  = '0;
        gnt_i  = 1'b0;
        rst_ni = 1'b0;
        #2;
        check_eq("rst_req_o", 32'(req_a), 32'h0);
        check_eq("rst_gnt_o", 32'(gnt_a), 32'h0);
        check_eq("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0);
        tick();
        rst_ni = 1'b1;
        #1;

        // 1: all requesting, every cycle a handshake
        req_i = 4'b1111;
        gnt_i = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("t1_idx%0d", c), 32'(idx_a), 32'(exp_idx1[c]));
            check_eq($sformatf("t1_lfsr%0d", c), 32'(dut.u_lfsr.lfsr_q), 32'(exp_lfsr1[c]));
            check_eq($sformatf("t1_gnt%0d", c), 32'(gnt_a), 32'(1) << exp_idx1[c]);
            tick();
        end
        check_eq("t1_lfsr_end", 32'(dut.u_lfsr.lfsr_q), 32'h000C);

        // 2: single requester stalled three cycles then granted
        do_reset();
        req_i = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            gnt_i = (c == 3);
            #1;
            check_eq($sformatf("t2_idx%0d", c), 32'(idx_a), 32'd2);
            check_eq($sformatf("t2_data%0d", c), data_a, 32'hD00D_0002);
            check_eq($sformatf("t2_gnt%0d", c), 32'(gnt_a), (c == 3) ? 32'b0100 : 32'b0);
            check_eq($sformatf("t2_lfsr%0d", c), 32'(dut.u_lfsr.lfsr_q), 32'h0);
            tick();
        end
        check_eq("t2_lfsr_end", 32'(dut.u_lfsr.lfsr_q), 32'h1);

        // 3: lock holds the decision, unlocked instance re-arbitrates
        do_reset();
        req_i = 4'b0100;
        gnt_i = 1'b0;
        #1;
        check_eq("t3_lock_c0", 32'(idx_a), 32'd2);
        check_eq("t3_nolock_c0", 32'(idx_b), 32'd2);
        tick();
        req_i = 4'b0101;
        #1;
        check_eq("t3_lock_c1", 32'(idx_a), 32'd2);
        check_eq("t3_nolock_c1", 32'(idx_b), 32'd0);
        gnt_i = 1'b1;
        #1;
        check_eq("t3_lock_gnt", 32'(gnt_a), 32'b0100);
        check_eq("t3_nolock_gnt", 32'(gnt_b), 32'b0001);
        tick();

        // 4: two requesters, starvation guard with MaxWait=2
        do_reset();
        req_i = 4'b1001;
        gnt_i = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("t4_plain%0d", c), 32'(idx_a), (c == 0) ? 32'd0 : 32'd3);
            check_eq($sformatf("t4_guard%0d", c), 32'(idx_c), 32'(exp_s4[c]));
            tick();
        end

        // 5: asynchronous reset discards a lock
        do_reset();
        req_i = 4'b1111;
        gnt_i = 1'b1;
        tick();
        req_i = 4'b0100;
        gnt_i = 1'b0;
        tick();
        req_i = 4'b1111;
        #1;
        check_eq("t5_locked", 32'(idx_a), 32'd2);
        check_eq("t5_lfsr_pre", 32'(dut.u_lfsr.lfsr_q), 32'h1);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_idx", 32'(idx_a), 32'd0);
        check_eq("t5_rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0);
        tick();
        rst_ni = 1'b1;
        #1;
        check_eq("t5_rel_idx", 32'(idx_a), 32'd0);

        // 6: downstream ready with no requests does nothing
        do_reset();
        req_i = 4'b0000;
        gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq($sformatf("t6_req%0d", c), 32'(req_a), 32'h0);
            check_eq($sformatf("t6_gnt%0d", c), 32'(gnt_a), 32'h0);
            tick();
        end
        check_eq("t6_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0);
        req_i = 4'b1001;
        #1;
        check_eq("t6_guard_idx", 32'(idx_c), 32'd0);
        tick();
        req_i = 4'b0000;
        gnt_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
